// File: rtl/master_port.sv
// Serial bus master: shifts a configuration frame out on control, then streams write words on wD
// or assembles read words from rD, with a ready timeout on reads.
module master_port #(
    parameter int unsigned ADDR_DEPTH = 2000,
    parameter int unsigned SLAVES     = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned S_ID_WIDTH = $clog2(SLAVES + 1),
    parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int unsigned FRAME_LEN  = 3 + S_ID_WIDTH + 2 + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [S_ID_WIDTH-1:0] slave_id,
    input  logic                  write,
    input  logic                  burst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [7:0]            burst_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_req,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned CfgW = $clog2(FRAME_LEN + 1);

    typedef enum logic [2:0] {StIdle, StCfg, StWaitRdy, StWdata, StRdata, StDone} state_e;

    state_e                state_q, state_d;
    logic [FRAME_LEN-1:0]  frame_q;
    logic [CfgW-1:0]       cfg_cnt_q;
    logic                  write_q;
    logic [8:0]            words_q;
    logic [8:0]            word_cnt_q;
    logic [BitW-1:0]       bit_cnt_q;
    logic [7:0]            wait_cnt_q;
    logic [DATA_WIDTH-1:0] wbuf_q;
    logic [DATA_WIDTH-1:0] rshift_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdata_valid_q;
    logic                  timeout_q;

    logic cfg_last, bit_last, last_word;

    assign cfg_last  = (cfg_cnt_q == CfgW'(FRAME_LEN - 1));
    assign bit_last  = (bit_cnt_q == BitW'(DATA_WIDTH - 1));
    assign last_word = (word_cnt_q == (words_q - 9'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCfg;
            StCfg:     if (cfg_last) state_d = write_q ? StWdata : StWaitRdy;
            StWaitRdy: begin
                if (ready) begin
                    state_d = StRdata;
                end else if (wait_cnt_q == 8'hFF) begin
                    state_d = StDone;
                end
            end
            StWdata:   if (bit_last && last_word) state_d = StDone;
            StRdata:   if (ready && bit_last && last_word) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        control     = (state_q == StCfg) && frame_q[FRAME_LEN-1];
        valid       = (state_q == StWdata);
        wD          = (state_q == StWdata) && wbuf_q[DATA_WIDTH-1];
        last        = ((state_q == StWdata) || (state_q == StRdata)) && last_word;
        wdata_req   = (state_q == StWdata) && bit_last && !last_word;
        rdata       = rdata_q;
        rdata_valid = rdata_valid_q;
        timeout     = timeout_q;
    end

    // Datapath: frame/word shifters, counters and read capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q       <= '0;
            cfg_cnt_q     <= '0;
            write_q       <= 1'b0;
            words_q       <= '0;
            word_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            wbuf_q        <= '0;
            rshift_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        frame_q    <= {3'b111, slave_id, write, burst, address};
                        cfg_cnt_q  <= '0;
                        write_q    <= write;
                        words_q    <= (burst && (burst_len != 8'd0)) ? {1'b0, burst_len} : 9'd1;
                        word_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        wait_cnt_q <= '0;
                        wbuf_q     <= wdata;
                        timeout_q  <= 1'b0;
                    end
                end
                StCfg: begin
                    frame_q   <= {frame_q[FRAME_LEN-2:0], 1'b0};
                    cfg_cnt_q <= cfg_cnt_q + CfgW'(1);
                end
                StWaitRdy: begin
                    if (!ready) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q == 8'hFF) timeout_q <= 1'b1;
                    end
                end
                StWdata: begin
                    if (bit_last) begin
                        // The user answers wdata_req combinationally; take the next word now.
                        bit_cnt_q  <= '0;
                        word_cnt_q <= word_cnt_q + 9'd1;
                        wbuf_q     <= wdata;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                        wbuf_q    <= {wbuf_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                StRdata: begin
                    if (ready) begin
                        rshift_q <= {rshift_q[DATA_WIDTH-2:0], rD};
                        if (bit_last) begin
                            rdata_q       <= {rshift_q[DATA_WIDTH-2:0], rD};
                            rdata_valid_q <= 1'b1;
                            bit_cnt_q     <= '0;
                            word_cnt_q    <= word_cnt_q + 9'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: frames, single/burst writes, reads with stall and timeout,
// asynchronous reset and start-while-busy.
module tb_master_port;

    localparam int DW = 32;
    localparam int SW = 2;
    localparam int AW = 11;
    localparam int FL = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] slave_id = '0;
    logic          write = 1'b0;
    logic          burst = 1'b0;
    logic [AW-1:0] address = '0;
    logic [7:0]    burst_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_req;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          control;
    logic          wD;
    logic          valid;
    logic          last;
    logic          rD = 1'b0;
    logic          ready = 1'b0;

    int errors = 0;
    int checks = 0;

    master_port dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .slave_id   (slave_id),
        .write      (write),
        .burst      (burst),
        .address    (address),
        .burst_len  (burst_len),
        .wdata      (wdata),
        .wdata_req  (wdata_req),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .control    (control),
        .wD         (wD),
        .valid      (valid),
        .last       (last),
        .rD         (rD),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [SW-1:0] sid, input logic wr, input logic bu,
                         input logic [AW-1:0] ad, input logic [7:0] bl, input logic [DW-1:0] wd);
        slave_id  = sid;
        write     = wr;
        burst     = bu;
        address   = ad;
        burst_len = bl;
        wdata     = wd;
        start     = 1'b1;
        step();
        start     = 1'b0;
        wdata     = 32'h5555_AAAA;
    endtask

    task automatic collect_frame(output logic [FL-1:0] f);
        f = '0;
        for (int i = 0; i < FL; i++) begin
            f = {f[FL-2:0], control};
            step();
        end
    endtask

    function automatic logic [40:0] all_outs();
        return {busy, done, timeout, control, wD, valid, last, wdata_req, rdata_valid, rdata};
    endfunction

    logic [FL-1:0] f;
    logic [DW-1:0] w;
    logic [95:0]   wv;
    logic [DW-1:0] rexp;
    int nv, nl, nll, nreq, nrv, n, k;

    initial begin
        // Reset state
        step();
        step();
        chk("reset_outputs", 64'(all_outs()), 64'h0);
        rst = 1'b0;
        step();
        chk("idle_outputs", 64'(all_outs()), 64'h0);

        // Single write
        issue(2'd1, 1'b1, 1'b0, 11'h005, 8'd0, 32'hA5A5_0F0F);
        chk("wr1_busy", 64'(busy), 64'h1);
        collect_frame(f);
        chk("wr1_frame", 64'(f), 64'(18'b111011000000000101));
        w = '0; nv = 0; nl = 0; nreq = 0;
        for (int i = 0; i < DW; i++) begin
            w = {w[DW-2:0], wD};
            nv += int'(valid);
            nl += int'(last);
            nreq += int'(wdata_req);
            step();
        end
        chk("wr1_word", 64'(w), 64'hA5A5_0F0F);
        chk("wr1_valid_cycles", 64'(nv), 64'd32);
        chk("wr1_last_cycles", 64'(nl), 64'd32);
        chk("wr1_wdata_req", 64'(nreq), 64'd0);
        chk("wr1_done", 64'(done), 64'h1);
        chk("wr1_valid_in_done", 64'(valid), 64'h0);
        step();
        chk("wr1_done_pulse", 64'(done), 64'h0);
        chk("wr1_busy_end", 64'(busy), 64'h0);

        // Burst write of 3 words
        issue(2'd0, 1'b1, 1'b1, 11'h100, 8'd3, 32'h1);
        collect_frame(f);
        chk("bw_frame", 64'(f), 64'(18'b111001100100000000));
        wv = '0; nv = 0; nl = 0; nll = 0; nreq = 0; k = 1;
        for (int i = 0; i < 96; i++) begin
            wv = {wv[94:0], wD};
            nv += int'(valid);
            if (last) begin
                if (i >= 64) nl++;
                else nll++;
            end
            if (wdata_req) begin
                nreq++;
                k++;
                wdata = DW'(k);
            end
            step();
        end
        chk("bw_word0", 64'(wv[95:64]), 64'h1);
        chk("bw_word1", 64'(wv[63:32]), 64'h2);
        chk("bw_word2", 64'(wv[31:0]), 64'h3);
        chk("bw_valid_cycles", 64'(nv), 64'd96);
        chk("bw_wdata_req", 64'(nreq), 64'd2);
        chk("bw_last_late", 64'(nl), 64'd32);
        chk("bw_last_early", 64'(nll), 64'd0);
        chk("bw_done", 64'(done), 64'h1);
        step();

        // Single read: 4 stalled WAIT_RDY cycles, then ready
        rexp = 32'hDEAD_BEEF;
        issue(2'd2, 1'b0, 1'b0, 11'h7FF, 8'd0, 32'h0);
        collect_frame(f);
        chk("rd_frame", 64'(f), 64'(18'b111100011111111111));
        for (int i = 0; i < 4; i++) step();
        chk("rd_wait_busy", 64'({busy, done, timeout, valid}), 64'b1000);
        ready = 1'b1;
        step();
        nrv = 0; nl = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            rD = rexp[i];
            nrv += int'(rdata_valid);
            nl += int'(last);
            step();
        end
        chk("rd_early_valid", 64'(nrv), 64'd0);
        chk("rd_last_cycles", 64'(nl), 64'd32);
        chk("rd_rdata_valid", 64'(rdata_valid), 64'h1);
        chk("rd_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("rd_done", 64'(done), 64'h1);
        ready = 1'b0;
        step();
        chk("rd_valid_pulse", 64'({rdata_valid, done, busy}), 64'b000);
        chk("rd_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

        // Reset between transactions clears rdata
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rdata", 64'(rdata), 64'h0);

        // Read with a 5-cycle stall in the middle of the word
        issue(2'd1, 1'b0, 1'b0, 11'h010, 8'd0, 32'h0);
        collect_frame(f);
        step();
        ready = 1'b1;
        step();
        nrv = 0; nl = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (i == 15) begin
                ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    rD = ~rD;
                    nl += int'(last);
                    nrv += int'(rdata_valid);
                    step();
                end
                ready = 1'b1;
            end
            rD = rexp[i];
            nl += int'(last);
            nrv += int'(rdata_valid);
            step();
        end
        chk("stall_rdata_cycles", 64'(nl), 64'd37);
        chk("stall_early_valid", 64'(nrv), 64'd0);
        chk("stall_rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("stall_valid_done", 64'({rdata_valid, done}), 64'b11);
        ready = 1'b0;
        step();

        // Timeout: ready never rises
        issue(2'd1, 1'b0, 1'b0, 11'h123, 8'd0, 32'h0);
        collect_frame(f);
        n = 0; nrv = 0;
        while (!done && n < 300) begin
            nrv += int'(rdata_valid);
            n++;
            step();
        end
        chk("to_wait_cycles", 64'(n), 64'd256);
        chk("to_flag_done", 64'({timeout, done, rdata_valid}), 64'b110);
        chk("to_no_rdata_valid", 64'(nrv), 64'd0);
        step();
        chk("to_hold_idle", 64'({timeout, busy}), 64'b10);
        step();
        chk("to_hold_later", 64'(timeout), 64'h1);

        // Start while busy must not disturb the frame; accepted start clears timeout
        issue(2'd3, 1'b1, 1'b0, 11'h2AA, 8'd0, 32'h8000_0001);
        chk("to_cleared", 64'(timeout), 64'h0);
        f = '0;
        for (int i = 0; i < FL; i++) begin
            start    = (i < 5);
            slave_id = '0;
            write    = 1'b0;
            address  = '0;
            wdata    = '0;
            f = {f[FL-2:0], control};
            step();
        end
        start = 1'b0;
        chk("abuse_frame", 64'(f), 64'(18'b111111001010101010));
        w = '0;
        for (int i = 0; i < DW; i++) begin
            w = {w[DW-2:0], wD};
            step();
        end
        chk("abuse_word", 64'(w), 64'h8000_0001);
        chk("abuse_done", 64'(done), 64'h1);
        step();

        // Asynchronous reset during frame bit 10
        issue(2'd3, 1'b1, 1'b0, 11'h3FF, 8'd0, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) step();
        chk("bit10_state", 64'({busy, control}), 64'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(all_outs()), 64'h0);
        step();
        rst = 1'b0;
        chk("reset_held_outputs", 64'(all_outs()), 64'h0);

        // First start after reset is accepted normally
        issue(2'd1, 1'b1, 1'b0, 11'h005, 8'd0, 32'h1234_5678);
        chk("post_rst_busy", 64'(busy), 64'h1);
        collect_frame(f);
        chk("post_rst_frame", 64'(f), 64'(18'b111011000000000101));
        w = '0;
        for (int i = 0; i < DW; i++) begin
            w = {w[DW-2:0], wD};
            step();
        end
        chk("post_rst_word", 64'(w), 64'h1234_5678);
        chk("post_rst_done", 64'(done), 64'h1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
